// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH programmable clock dividers with tick strobes, 50% slow clocks and shared phase sync
// ports: clk, reset (sync, active-high); en per-channel count enable; sync phase-aligns all channels;
//        wr_en/wr_ch/wr_div divisor write; tick terminal-count strobe; slow_clk divided clock;
//        pend high while a written divisor waits for the channel's next terminal count
module clk_divider_multi #(
  parameter int WIDTH       = 26,
  parameter int NUM_CH      = 4,
  parameter int DEFAULT_DIV = 9999999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [WIDTH-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] slow_clk,
  output logic [NUM_CH-1:0] pend
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt, r_div, r_pdiv;
    logic             r_pend, r_tick, r_slow;
    logic             w_wr, w_tc;
    assign w_wr        = wr_en && (wr_ch == 4'(i));
    assign w_tc        = en[i] && (r_cnt == r_div);
    assign tick[i]     = r_tick;
    assign slow_clk[i] = r_slow;
    assign pend[i]     = r_pend;
    always_ff @(posedge clk)
      if (reset) begin
        r_cnt  <= '0;
        r_div  <= WIDTH'(DEFAULT_DIV);
        r_pdiv <= '0;
        r_pend <= 1'b0;
        r_tick <= 1'b0;
        r_slow <= 1'b0;
      end else if (sync) begin
        // a write landing with sync is applied at once, as if it had been pending
        r_cnt  <= '0;
        r_slow <= 1'b0;
        r_tick <= 1'b0;
        r_div  <= w_wr ? wr_div : r_pend ? r_pdiv : r_div;
        r_pend <= 1'b0;
      end else if (w_wr && !en[i]) begin
        r_div  <= wr_div;
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_tick <= w_tc;
        r_slow <= r_slow ^ w_tc;
        r_cnt  <= !en[i] ? r_cnt : w_tc ? '0 : r_cnt + 1'b1;
        // terminal count consumes the old pending value; a same-cycle write re-arms it
        if (w_tc && r_pend) r_div <= r_pdiv;
        if (w_wr) r_pdiv <= wr_div;
        r_pend <= w_wr || (r_pend && !w_tc);
      end
  end
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: directed plan checks plus randomized run against a behavioural channel model
module tb_clk_divider_multi;
  localparam int W = 8, N = 4, DEF = 3;
  logic         clk = 0, reset = 1, sync = 0, wr_en = 0;
  logic [N-1:0] en = '0;
  logic [3:0]   wr_ch = '0;
  logic [W-1:0] wr_div = '0;
  logic [N-1:0] tick, slow_clk, pend;
  int n_cmp = 0, n_err = 0;
  int m_cnt[N], m_div[N], m_pdiv[N];
  bit m_pend[N], m_tick[N], m_slow[N];

  clk_divider_multi #(.WIDTH(W), .NUM_CH(N), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .tick(tick), .slow_clk(slow_clk), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each channel counts 0..div, so a tick occurs every div+1 enabled cycles.
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit w, tc;
      w = wr_en && (int'(wr_ch) == c);
      if (reset) begin
        m_cnt[c] = 0; m_div[c] = DEF; m_pdiv[c] = 0;
        m_pend[c] = 0; m_tick[c] = 0; m_slow[c] = 0;
      end else if (sync) begin
        if (w) m_div[c] = int'(wr_div);
        else if (m_pend[c]) m_div[c] = m_pdiv[c];
        m_cnt[c] = 0; m_slow[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
      end else if (w && !en[c]) begin
        m_div[c] = int'(wr_div); m_cnt[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
      end else begin
        tc = en[c] && (m_cnt[c] == m_div[c]);
        m_tick[c] = tc;
        if (en[c]) m_cnt[c] = (m_cnt[c] + 1) % (m_div[c] + 1);
        if (tc) begin
          m_slow[c] = !m_slow[c];
          if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
        end
        if (w) begin m_pdiv[c] = int'(wr_div); m_pend[c] = 1; end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] et, es, ep;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < N; c++) begin
      et[c] = m_tick[c]; es[c] = m_slow[c]; ep[c] = m_pend[c];
    end
    chk("model_tick", tick, et);
    chk("model_slow", slow_clk, es);
    chk("model_pend", pend, ep);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    step();
    chk("reset_outputs", {tick, slow_clk, pend}, '0);
    reset = 0; en = '1;
    steps(3);
    chk("first_ticks_low", tick[0], 0);
    step();
    chk("tick_cyc4", tick[0], 1);
    chk("slow_cyc4", slow_clk[0], 1);
    steps(4);
    chk("tick_cyc8", tick[0], 1);
    chk("slow_cyc8", slow_clk[0], 0);
    step();
    wr_en = 1; wr_ch = 0; wr_div = 1;
    step();
    wr_en = 0;
    chk("pend_after_wr", pend[0], 1);
    step();
    chk("old_period_kept", tick[0], 0);
    step();
    chk("tick_cyc12", tick[0], 1);
    chk("pend_applied", pend[0], 0);
    step();
    chk("new_div_gap", tick[0], 0);
    step();
    chk("new_div_tick", tick[0], 1);
    en[1] = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("dis_tick", tick[1], 0);
      chk("dis_slow_hold", slow_clk[1], 1);
    end
    en[1] = 1;
    step();
    chk("resume_no_tick", tick[1], 0);
    step();
    chk("resume_tick", tick[1], 1);
    en[2] = 0; wr_en = 1; wr_ch = 2; wr_div = 0;
    step();
    wr_en = 0; en[2] = 1;
    chk("dis_wr_nopend", pend[2], 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("div0_tick", tick[2], 1);
      chk("div0_slow", slow_clk[2], (k % 2 == 0) ? 0 : 1);
    end
    wr_en = 1; wr_ch = 0; wr_div = 3;
    step();
    wr_ch = 3; wr_div = 5;
    step();
    chk("pend3_set", pend[3], 1);
    wr_en = 0; sync = 1;
    step();
    sync = 0;
    chk("sync_clear", {tick, slow_clk, pend}, '0);
    steps(3);
    chk("sync_ch0_early", tick[0], 0);
    step();
    chk("sync_ch0_tick", tick[0], 1);
    chk("sync_ch3_early", tick[3], 0);
    step();
    chk("sync_ch3_gap", tick[3], 0);
    step();
    chk("sync_ch3_tick", tick[3], 1);
    wr_en = 1; wr_ch = 7; wr_div = 0;
    step();
    chk("bad_ch_ignored", pend, 0);
    wr_ch = 1; wr_div = 7;
    step();
    wr_en = 0;
    chk("pend1_set", pend, 4'b0010);
    reset = 1;
    step();
    reset = 0;
    chk("reset_clears", {tick, slow_clk, pend}, '0);
    steps(3);
    step();
    chk("default_div_restored", tick, 4'hF);
    for (int k = 0; k < 2000; k++) begin
      reset  = ($urandom_range(199) == 0);
      sync   = ($urandom_range(49) == 0);
      wr_en  = ($urandom_range(3) == 0);
      wr_ch  = 4'($urandom_range(7));
      wr_div = W'($urandom_range(7));
      for (int c = 0; c < N; c++) en[c] = ($urandom_range(7) != 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Parametrised, multi-channel successor to the single fixed 1 Hz divider.
- NUM_CH independent channels, each with a runtime-programmable divisor, an enable, a one-cycle tick strobe and a 50%-duty toggled slow clock.
- A shared sync input phase-aligns all channels.
- Sits beside the board clock (50 MHz) and feeds timers, display scanners and blinkers.

Parameters:
- WIDTH, 26, bit width of each divisor and counter.
- NUM_CH, 4, number of channels (1..16).
- DEFAULT_DIV, 9999999, divisor loaded into every channel at reset. Gives a 1 Hz slow_clk from 50 MHz would need 24999999; 9999999 gives 2.5 Hz.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- en, input, NUM_CH, per-channel count enable.
- sync, input, 1, synchronous phase-align strobe for all channels.
- wr_en, input, 1, divisor write strobe.
- wr_ch, input, 4, target channel index for the write.
- wr_div, input, WIDTH, new divisor value.
- tick, output, NUM_CH, one-cycle strobe per channel at terminal count.
- slow_clk, output, NUM_CH, toggled divided clock per channel.
- pend, output, NUM_CH, high while a channel holds a written but not yet applied divisor.

Behaviour:
- Reset is synchronous: sampled on the posedge clk only.
  - In the reset cycle, every channel takes counter=0, div=DEFAULT_DIV, pending=0.
  - All outputs are registered and all reset to 0: tick=0, slow_clk=0, pend=0.
- Per-channel count, on each posedge clk when en[i]=1 and there is no sync:
  - counter != div: counter+1 and tick[i]<=0.
  - counter == div (terminal count):
    - counter<=0, tick[i]<=1 for exactly one cycle, slow_clk[i]<=~slow_clk[i].
    - If pending, div<=pending value, pending cleared, pend[i]<=0.
- Resulting timing:
  - Tick period is div+1 clk cycles.
  - slow_clk period is 2*(div+1) clk cycles, 50% duty.
  - div=0 gives tick held high continuously and slow_clk toggling every cycle.
- en[i]=0:
  - counter and slow_clk[i] hold, tick[i]<=0.
  - Re-enabling resumes from the held count, with no extra tick.
- Divisor write: wr_en=1 with wr_ch<NUM_CH.
  - Channel enabled: the value is stored as pending and pend[i]<=1. It is applied only at the next terminal count, so the running period is never truncated or glitched. A second write before that point overwrites pending; last write wins.
  - Channel disabled (en[i]=0 in the write cycle): div<=wr_div immediately, counter<=0, pending cleared, pend[i]<=0.
  - wr_ch>=NUM_CH: the write is ignored and no state changes.
- sync=1, which overrides counting in all channels:
  - counter<=0, slow_clk<=0, tick<=0.
  - Any pending divisor is applied and pend cleared.
  - Applies regardless of en.
- Simultaneous events and priority:
  - Priority order: reset > sync > write-to-disabled > terminal count/count.
  - Terminal count in the same cycle as a write to that channel: the terminal-count action uses the old pending (if any). The new write becomes pending afterwards, so pend stays 1.
  - sync in the same cycle as a write: sync wins. The written value is then applied immediately, as if pending, and pend=0.
- Arithmetic: all counting is unsigned modulo 2^WIDTH. The counter can never exceed div, because of the load rules above.
- Latency: wr to pend[i] is 1 cycle. sync to counter=0 is 1 cycle.

Test Plan:
- Reset with DEFAULT_DIV=3, en=all 1 -> tick[0] high on cycles 4, 8, 12 after reset release; slow_clk[0] toggles at the same edges (period 8); pend=0.
- Write div=1 to ch0 mid-period (counter=1) -> pend[0]=1 next cycle. The current period completes at 4 cycles; thereafter ticks every 2 cycles and pend[0]=0.
- en[1]=0 for 5 cycles at counter=2 -> tick[1]=0 and slow_clk[1] held throughout; after re-enable the next tick arrives 2 cycles later (counter 2->3->wrap).
- Write div=0 to disabled ch2, then enable -> counter=0; tick[2] is asserted on every cycle and slow_clk[2] toggles each cycle.
- Pulse sync with channels at differing counts and ch3 pending div=5 -> all counters 0, all slow_clk=0, pend[3]=0; ch3 ticks 6 cycles later and ch0 ticks 4 cycles later.
- Write with wr_ch=7 (NUM_CH=4) -> no change to any div or pend. Assert reset during a pending write -> pend=0 and div=DEFAULT_DIV.
